c3routing_chnl_edge_term: RTL and testbench

C3ROUTING_CHNL_EDGE_TERM -- requirements
Module: c3routing_chnl_edge_term

---
 rtl/c3routing_chnl_edge_term.sv | 202 ++++++++++++++++++++
 tb/tb_c3routing_chnl_edge_term.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c3routing_chnl_edge_term.sv
// ---------------------------------------------------------------------------
// c3routing_chnl_edge_term
//
// Purpose:
//   Termination block for the routing-channel edge. It answers AVMM
//   configuration accesses with a fixed number of wait states and a constant
//   read pattern. It ties off the DFT DLL and redundancy/direct-out chain
//   outputs, and it closes the boundary-scan chain.
//
// Optional feature (macro C3ROUTING_EDGE_ACCESS_CNT_EN):
//   When the macro is defined, a 16-bit saturating access counter is added.
//   It counts every accepted transaction. A read at CNT_ADDR returns the
//   counter value as it was before that read is counted. A write at CNT_ADDR
//   clears the counter. When the macro is undefined, every read returns
//   RD_PATTERN and writes are accepted and discarded.
//
// Ports:
//   i_cfg_avmm_clk           clock
//   i_cfg_avmm_rst_n         asynchronous active-low reset
//   i_read / i_write         AVMM request strobes
//   i_addr / i_wdata         request address / write data
//   o_waitreq                low only in the cycle a request is accepted
//   o_rdatavalid / o_rdata   one-cycle read response (data 0 otherwise)
//   o_proto_err              sticky flag: read and write requested together
//   o_aibdftdll2adjch        DFT DLL tie-off (all 0)
//   o_red_idataselb          per-chain tie-off (all 0)
//   o_txen                   per-chain tie-off (all 1)
//   o_red_shift_en_out       per-chain tie-off (all 0)
//   o_directout_data         per-chain tie-off (all 0)
//   i_jtag_last_bs_chain_in  boundary-scan chain return input
//   o_jtag_last_bs_chain_out combinational copy of the scan input
// ---------------------------------------------------------------------------
module c3routing_chnl_edge_term #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 17,
    parameter int                NUM_CHAIN   = 2,
    parameter int                DLL_W       = 13,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] RD_PATTERN  = '0,
    parameter logic [ADDR_W-1:0] CNT_ADDR    = '0
) (
    input  logic                 i_cfg_avmm_clk,
    input  logic                 i_cfg_avmm_rst_n,
    input  logic                 i_read,
    input  logic                 i_write,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic                 o_waitreq,
    output logic                 o_rdatavalid,
    output logic [DATA_W-1:0]    o_rdata,
    output logic                 o_proto_err,
    output logic [DLL_W-1:0]     o_aibdftdll2adjch,
    output logic [NUM_CHAIN-1:0] o_red_idataselb,
    output logic [NUM_CHAIN-1:0] o_txen,
    output logic [NUM_CHAIN-1:0] o_red_shift_en_out,
    output logic [NUM_CHAIN-1:0] o_directout_data,
    input  logic                 i_jtag_last_bs_chain_in,
    output logic                 o_jtag_last_bs_chain_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // WAIT_CYCLES is limited to 0-15, so a 4-bit counter is always enough.
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t              state;
    logic [3:0]          wait_cnt;
    logic                resp_vld_p1;
    logic [DATA_W-1:0]   resp_data_p1;
    logic                proto_err;

    logic                req_any;
    logic                req_both;
    logic                accept_p0;
    logic [DATA_W-1:0]   rd_word_p0;

    // Write data is never stored. Address and CNT_ADDR are only consumed
    // when the access counter is built in.
    logic                unused_inputs;
    assign unused_inputs = ^{i_wdata, i_addr, CNT_ADDR};

    // Saturating 16-bit increment used by the access counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

    // ---------------------------------------------------------------------
    // Request decode (combinational, stage p0)
    // ---------------------------------------------------------------------
    assign req_any   = i_read | i_write;
    assign req_both  = i_read & i_write;
    // Acceptance needs a live request in the final wait cycle. A request
    // that appears in RESP or IDLE never lowers o_waitreq.
    assign accept_p0 = (state == ST_WAIT) && (wait_cnt == 4'd0) && req_any;
    assign o_waitreq = ~accept_p0;

`ifdef C3ROUTING_EDGE_ACCESS_CNT_EN
    logic [15:0] acc_cnt;

    // Counter value is sampled before this access is counted.
    assign rd_word_p0 = (i_addr == CNT_ADDR) ? DATA_W'(acc_cnt) : RD_PATTERN;

    always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
        if (!i_cfg_avmm_rst_n) begin
            acc_cnt <= 16'd0;
        end else if (accept_p0) begin
            // A write at CNT_ADDR clears the counter, and the clear wins over
            // the increment. When both strobes are high the access is a
            // read, so it never clears.
            if (!i_read && (i_addr == CNT_ADDR)) begin
                acc_cnt <= 16'd0;
            end else begin
                acc_cnt <= sat_inc16(acc_cnt);
            end
        end
    end
`else
    assign rd_word_p0 = RD_PATTERN;
`endif

    // ---------------------------------------------------------------------
    // Control FSM and registered response (stage p1)
    // ---------------------------------------------------------------------
    always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
        if (!i_cfg_avmm_rst_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            resp_vld_p1  <= 1'b0;
            resp_data_p1 <= '0;
            proto_err    <= 1'b0;
        end else begin
            // Simultaneous strobes count as an error only while a request
            // can actually be taken. In RESP, requests are ignored.
            if (req_both && (state != ST_RESP)) begin
                proto_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LD;
                    end
                end

                ST_WAIT: begin
                    if (!req_any) begin
                        // Master withdrew the request: drop it silently.
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (i_read) begin
                        // A read, or read and write together, gets a response.
                        state        <= ST_RESP;
                        resp_vld_p1  <= 1'b1;
                        resp_data_p1 <= rd_word_p0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_RESP: begin
                    // The response is only one cycle long. Clearing the data
                    // here keeps o_rdata at 0 while o_rdatavalid is low.
                    state        <= ST_IDLE;
                    resp_vld_p1  <= 1'b0;
                    resp_data_p1 <= '0;
                end

                default: begin
                    state        <= ST_IDLE;
                    wait_cnt     <= 4'd0;
                    resp_vld_p1  <= 1'b0;
                    resp_data_p1 <= '0;
                end
            endcase
        end
    end

    assign o_rdatavalid = resp_vld_p1;
    assign o_rdata      = resp_data_p1;
    assign o_proto_err  = proto_err;

    // ---------------------------------------------------------------------
    // Static tie-offs and scan-chain return
    // ---------------------------------------------------------------------
    assign o_aibdftdll2adjch        = '0;
    assign o_red_idataselb          = '0;
    assign o_txen                   = '1;
    assign o_red_shift_en_out       = '0;
    assign o_directout_data         = '0;
    assign o_jtag_last_bs_chain_out = i_jtag_last_bs_chain_in;

endmodule

// File: tb/tb_c3routing_chnl_edge_term.sv
// ---------------------------------------------------------------------------
// tb_c3routing_chnl_edge_term
//
// Self-checking bench for c3routing_chnl_edge_term. Each cycle, the DUT
// outputs are compared against a timestamp-based reference model. In that
// model, a request first seen at the end of cycle t is accepted in cycle
// t+1+WAIT_CYCLES, provided it is still held. A read then answers in the
// following cycle.
// ---------------------------------------------------------------------------
module tb_c3routing_chnl_edge_term;

    localparam int                DATA_W      = 32;
    localparam int                ADDR_W      = 17;
    localparam int                NUM_CHAIN   = 4;
    localparam int                DLL_W       = 13;
    localparam int                WC          = 2;
    localparam logic [DATA_W-1:0] RD_PATTERN  = 32'hDEADBEEF;
    localparam logic [ADDR_W-1:0] CNT_ADDR    = 17'h00040;

    logic                 clk;
    logic                 rst_n;
    logic                 i_read;
    logic                 i_write;
    logic [ADDR_W-1:0]    i_addr;
    logic [DATA_W-1:0]    i_wdata;
    logic                 o_waitreq;
    logic                 o_rdatavalid;
    logic [DATA_W-1:0]    o_rdata;
    logic                 o_proto_err;
    logic [DLL_W-1:0]     o_aibdftdll2adjch;
    logic [NUM_CHAIN-1:0] o_red_idataselb;
    logic [NUM_CHAIN-1:0] o_txen;
    logic [NUM_CHAIN-1:0] o_red_shift_en_out;
    logic [NUM_CHAIN-1:0] o_directout_data;
    logic                 jtag_in;
    logic                 jtag_out;

    c3routing_chnl_edge_term #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .NUM_CHAIN   (NUM_CHAIN),
        .DLL_W       (DLL_W),
        .WAIT_CYCLES (WC),
        .RD_PATTERN  (RD_PATTERN),
        .CNT_ADDR    (CNT_ADDR)
    ) dut (
        .i_cfg_avmm_clk           (clk),
        .i_cfg_avmm_rst_n         (rst_n),
        .i_read                   (i_read),
        .i_write                  (i_write),
        .i_addr                   (i_addr),
        .i_wdata                  (i_wdata),
        .o_waitreq                (o_waitreq),
        .o_rdatavalid             (o_rdatavalid),
        .o_rdata                  (o_rdata),
        .o_proto_err              (o_proto_err),
        .o_aibdftdll2adjch        (o_aibdftdll2adjch),
        .o_red_idataselb          (o_red_idataselb),
        .o_txen                   (o_txen),
        .o_red_shift_en_out       (o_red_shift_en_out),
        .o_directout_data         (o_directout_data),
        .i_jtag_last_bs_chain_in  (jtag_in),
        .o_jtag_last_bs_chain_out (jtag_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (timestamps, not FSM states)
    int          cyc;
    bit          in_txn;
    int          t_seen;
    int          t_resp;
    logic [31:0] resp_m;
    bit          proto_m;
    int          cnt_m;

    // Last observed outputs from step()
    logic        last_waitreq;
    logic        last_vld;
    logic [31:0] last_rdata;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        in_txn  = 1'b0;
        t_seen  = -100;
        t_resp  = -100;
        resp_m  = '0;
        proto_m = 1'b0;
        cnt_m   = 0;
    endtask

    // Drive one cycle, check the outputs against the model, then advance the
    // model across the clock edge.
    task automatic step(input bit rd, input bit wr, input logic [ADDR_W-1:0] a);
        bit          exp_acc;
        bit          exp_vld;
        logic [31:0] exp_data;
        @(negedge clk);
        i_read  = rd;
        i_write = wr;
        i_addr  = a;
        i_wdata = $urandom;
        #1;
        exp_acc  = in_txn && (cyc == t_seen + 1 + WC) && (rd || wr);
        exp_vld  = (cyc == t_resp);
        exp_data = exp_vld ? resp_m : 32'd0;
        check_val("waitreq", 64'(o_waitreq), 64'(!exp_acc));
        check_val("rdatavalid", 64'(o_rdatavalid), 64'(exp_vld));
        check_val("rdata", 64'(o_rdata), 64'(exp_data));
        check_val("proto_err", 64'(o_proto_err), 64'(proto_m));
        last_waitreq = o_waitreq;
        last_vld     = o_rdatavalid;
        last_rdata   = o_rdata;
        @(posedge clk);
        if (cyc == t_resp) begin
            // The response cycle ignores any request.
        end else if (in_txn) begin
            if (!(rd || wr)) begin
                in_txn = 1'b0;
            end else begin
                if (rd && wr) proto_m = 1'b1;
                if (cyc == t_seen + 1 + WC) begin
                    in_txn = 1'b0;
                    if (rd) begin
                        t_resp = cyc + 1;
                        resp_m = RD_PATTERN;
`ifdef C3ROUTING_EDGE_ACCESS_CNT_EN
                        if (a == CNT_ADDR) resp_m = 32'(cnt_m);
`endif
                    end
`ifdef C3ROUTING_EDGE_ACCESS_CNT_EN
                    if (!rd && a == CNT_ADDR) cnt_m = 0;
                    else if (cnt_m < 65535) cnt_m = cnt_m + 1;
`endif
                end
            end
        end else if (rd || wr) begin
            in_txn = 1'b1;
            t_seen = cyc;
            if (rd && wr) proto_m = 1'b1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        i_read  = 1'b0;
        i_write = 1'b0;
        #1;
        check_val("rst_waitreq", 64'(o_waitreq), 64'd1);
        check_val("rst_rdatavalid", 64'(o_rdatavalid), 64'd0);
        check_val("rst_rdata", 64'(o_rdata), 64'd0);
        check_val("rst_proto_err", 64'(o_proto_err), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = cyc + 2;
    endtask

    // Full transaction: the request is held until it is accepted, then one
    // idle cycle follows, in which any read response appears.
    task automatic xact(input bit rd, input bit wr, input logic [ADDR_W-1:0] a);
        for (int k = 0; k < WC + 2; k++) step(rd, wr, a);
        step(1'b0, 1'b0, a);
    endtask

    initial begin
        int  lat;
        bit  cur_rd;
        bit  cur_wr;
        logic [ADDR_W-1:0] cur_a;
        int  r;

        cyc     = 0;
        rst_n   = 1'b0;
        i_read  = 1'b0;
        i_write = 1'b0;
        i_addr  = '0;
        i_wdata = '0;
        jtag_in = 1'b0;
        model_reset();
        #1;
        check_val("init_waitreq", 64'(o_waitreq), 64'd1);
        check_val("init_rdatavalid", 64'(o_rdatavalid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Tie-offs and scan return
        check_val("txen", 64'(o_txen), 64'hF);
        check_val("red_idataselb", 64'(o_red_idataselb), 64'h0);
        check_val("red_shift_en", 64'(o_red_shift_en_out), 64'h0);
        check_val("directout", 64'(o_directout_data), 64'h0);
        check_val("dftdll", 64'(o_aibdftdll2adjch), 64'h0);
        for (int k = 0; k < 4; k++) begin
            jtag_in = ~jtag_in;
            #1;
            check_val("jtag_mirror", 64'(jtag_out), 64'(jtag_in));
        end

        // Read latency: first valid is WC+2 cycles after the request is seen
        do_reset();
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 17'd5);
            if (last_vld && lat < 0) begin
                lat = k;
                check_val("lat_rdata", 64'(last_rdata), 64'(RD_PATTERN));
                break;
            end
        end
        check_val("read_latency", 64'(lat), 64'(WC + 2));
        step(1'b0, 1'b0, 17'd0);
        step(1'b0, 1'b0, 17'd0);

        // Held write: waitreq is 1 in cycles 0..WC and 0 in cycle WC+1
        do_reset();
        for (int k = 0; k <= WC + 1; k++) begin
            step(1'b0, 1'b1, 17'd5);
            check_val("wr_waitreq", 64'(last_waitreq), 64'((k == WC + 1) ? 0 : 1));
        end
        step(1'b0, 1'b0, 17'd0);
        step(1'b0, 1'b0, 17'd0);

        // Both strobes high: sticky error, handled as a read
        do_reset();
        xact(1'b1, 1'b1, 17'd5);
        check_val("both_resp_vld", 64'(last_vld), 64'd1);
        check_val("both_resp_data", 64'(last_rdata), 64'(RD_PATTERN));
        xact(1'b0, 1'b1, 17'd6);
        check_val("proto_sticky", 64'(o_proto_err), 64'd1);

        // Reset asserted asynchronously while a read is in WAIT
        do_reset();
        step(1'b1, 1'b0, 17'd5);
        step(1'b1, 1'b0, 17'd5);
        #2;
        rst_n   = 1'b0;
        i_read  = 1'b0;
        #1;
        check_val("async_waitreq", 64'(o_waitreq), 64'd1);
        check_val("async_rdatavalid", 64'(o_rdatavalid), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 17'd5);

`ifdef C3ROUTING_EDGE_ACCESS_CNT_EN
        do_reset();
        for (int k = 0; k < 3; k++) xact(1'b0, 1'b1, 17'd9);
        xact(1'b1, 1'b0, CNT_ADDR);
        check_val("cnt_after3", 64'(last_rdata), 64'd3);
        xact(1'b0, 1'b1, CNT_ADDR);
        xact(1'b1, 1'b0, CNT_ADDR);
        check_val("cnt_cleared", 64'(last_rdata), 64'd0);
`endif

        // Randomized traffic with occasional resets
        do_reset();
        cur_rd = 1'b0;
        cur_wr = 1'b0;
        cur_a  = '0;
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                do_reset();
            end else if (r < 30) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: begin cur_rd = 1'b0; cur_wr = 1'b0; end
                    3, 4, 5: begin cur_rd = 1'b1; cur_wr = 1'b0; end
                    6, 7, 8: begin cur_rd = 1'b0; cur_wr = 1'b1; end
                    default: begin
                        cur_rd = ($urandom_range(0, 7) == 0);
                        cur_wr = cur_rd;
                    end
                endcase
                case ($urandom_range(0, 2))
                    0:       cur_a = CNT_ADDR;
                    1:       cur_a = 17'd5;
                    default: cur_a = ADDR_W'($urandom);
                endcase
            end
            step(cur_rd, cur_wr, cur_a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
